// File: rtl/reg_xing_pkg.sv
// ---------------------------------------------------------------------------
// reg_xing_pkg
//   Shared definitions for the register crossing feeder.
//   - xing_state_e : feeder FSM states (IDLE / SEND / HOLD)
//   - STAT_WIDTH   : width of the statistics counters
//   - sat_inc      : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package reg_xing_pkg;

  localparam int STAT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } xing_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_xing_feeder_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector over a request vector.
//   The search starts at last+1 and wraps at NUM_REGS, so the index that was
//   served most recently has the lowest priority.
//
// Ports
//   req       in  NUM_REGS    request (dirty) vector
//   last      in  ADDR_WIDTH  index granted most recently
//   grant     out ADDR_WIDTH  selected index (0 when nothing is requested)
//   any_valid out 1           at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NUM_REGS   = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]   req,
  input  logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] grant,
  output logic                  any_valid
);

  int idx;

  // Walk the offsets from farthest to nearest; the last hit written is the
  // nearest requester after 'last', which is the round-robin winner.
  always_comb begin
    grant     = '0;
    any_valid = |req;
    idx       = 0;
    for (int off = NUM_REGS; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REGS;
      if (req[idx]) begin
        grant = ADDR_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_xing_feeder.sv
// ---------------------------------------------------------------------------
// reg_xing_feeder
//   Shadow register file that forwards changed registers, one at a time, to a
//   downstream clock-crossing stage. Writes land in a shadow copy and mark the
//   register dirty; a round-robin FSM picks dirty registers and hands
//   {index, value} to the crossing stage with a one-cycle push. Repeated
//   writes to a register that has not been sent yet coalesce, so only the
//   newest value travels.
//
// Ports
//   iclk            in   1                       clock
//   ireset          in   1                       synchronous active-high reset
//   wr_en           in   1                       register write strobe
//   wr_addr         in   ADDR_WIDTH              write index (>= NUM_REGS ignored)
//   wr_data         in   DATA_WIDTH              write value
//   xing_data       out  ADDR_WIDTH+DATA_WIDTH   {index, value} to crossing stage
//   xing_push       out  1                       one-cycle push to crossing stage
//   xing_ready      in   1                       crossing stage ready
//   pending         out  NUM_REGS                dirty bitmap
//   idle            out  1                       nothing dirty and FSM in IDLE
//   stat_coalesced  out  STAT_WIDTH              coalesced-write counter
//   stat_sent       out  STAT_WIDTH              push counter
//
// Configuration
//   REG_XING_FEEDER_STATS_EN : when defined, stat_coalesced / stat_sent are
//   saturating counters; otherwise both ports are tied to zero.
// ---------------------------------------------------------------------------
module reg_xing_feeder
  import reg_xing_pkg::*;
#(
  parameter  int NUM_REGS   = 8,
  parameter  int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                             iclk,
  input  logic                             ireset,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] xing_data,
  output logic                             xing_push,
  input  logic                             xing_ready,
  output logic [NUM_REGS-1:0]              pending,
  output logic                             idle,
  output logic [STAT_WIDTH-1:0]            stat_coalesced,
  output logic [STAT_WIDTH-1:0]            stat_sent
);

  logic [DATA_WIDTH-1:0]            shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]            shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0]              dirty_q, dirty_d;
  logic [ADDR_WIDTH-1:0]            last_q, last_d;
  xing_state_e                      state_q, state_d;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] xing_data_q, xing_data_d;
  logic                             xing_push_q, xing_push_d;

  logic [ADDR_WIDTH-1:0]            grant;
  logic                             any_valid;
  logic                             wr_legal;
  logic                             wr_accept;
  logic                             pick;

  // Only non-power-of-two register counts can see out-of-range addresses.
  assign wr_legal  = ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(NUM_REGS));
  assign wr_accept = wr_en && wr_legal;
  assign pick      = (state_q == IDLE) && any_valid;

  rr_pick #(
    .NUM_REGS (NUM_REGS)
  ) u_rr_pick (
    .req       (dirty_q),
    .last      (last_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Next-state logic. The pick samples shadow_q, so a write to the picked
  // index in the same cycle sends the old value; the write is applied after
  // the pick's dirty clear so the register stays dirty and goes out again.
  always_comb begin
    shadow_d    = shadow_q;
    dirty_d     = dirty_q;
    last_d      = last_q;
    state_d     = state_q;
    xing_data_d = xing_data_q;
    xing_push_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick) begin
          dirty_d[grant] = 1'b0;
          last_d         = grant;
          xing_data_d    = {grant, shadow_q[grant]};
          state_d        = SEND;
        end
      end
      SEND: begin
        if (xing_ready) begin
          state_d     = HOLD;
          xing_push_d = 1'b1;
        end
      end
      // HOLD covers the crossing stage's one-cycle delay in dropping ready.
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_accept) begin
      shadow_d[wr_addr] = wr_data;
      dirty_d[wr_addr]  = 1'b1;
    end
  end

  // State registers; reset drops the in-flight entry and every pending one.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
      dirty_q     <= '0;
      last_q      <= ADDR_WIDTH'(NUM_REGS - 1);
      state_q     <= IDLE;
      xing_data_q <= '0;
      xing_push_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      dirty_q     <= dirty_d;
      last_q      <= last_d;
      state_q     <= state_d;
      xing_data_q <= xing_data_d;
      xing_push_q <= xing_push_d;
    end
  end

  assign xing_data = xing_data_q;
  assign xing_push = xing_push_q;
  assign pending   = dirty_q;
  assign idle      = (state_q == IDLE) && (dirty_q == '0);

`ifdef REG_XING_FEEDER_STATS_EN
  logic [STAT_WIDTH-1:0] coalesced_q, coalesced_d;
  logic [STAT_WIDTH-1:0] sent_q, sent_d;
  logic                  coalesce_hit;

  // A write coalesces only if it overwrites a value that is still waiting;
  // a write to the index being picked this cycle starts a fresh entry.
  always_comb begin
    coalesce_hit = wr_accept && dirty_q[wr_addr] && !(pick && (grant == wr_addr));
    coalesced_d  = coalesce_hit ? sat_inc(coalesced_q) : coalesced_q;
    sent_d       = xing_push_d ? sat_inc(sent_q) : sent_q;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      coalesced_q <= '0;
      sent_q      <= '0;
    end else begin
      coalesced_q <= coalesced_d;
      sent_q      <= sent_d;
    end
  end

  assign stat_coalesced = coalesced_q;
  assign stat_sent      = sent_q;
`else
  assign stat_coalesced = '0;
  assign stat_sent      = '0;
`endif

endmodule

// File: tb/tb_reg_xing_feeder.sv
// ---------------------------------------------------------------------------
// tb_reg_xing_feeder
//   Directed and random stimulus for reg_xing_feeder with a transaction-level
//   reference model (shadow array, dirty set, round-robin pointer, timestamps
//   for when the feeder is free again).
//   Honors REG_XING_FEEDER_STATS_EN for the expected counter values.
// ---------------------------------------------------------------------------
module tb_reg_xing_feeder;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int XW = AW + DW;

`ifdef REG_XING_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          iclk = 1'b0;
  logic          ireset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          xing_ready = 1'b0;
  logic [XW-1:0] xing_data;
  logic          xing_push;
  logic [NR-1:0] pending;
  logic          idle;
  logic [15:0]   stat_coalesced;
  logic [15:0]   stat_sent;

  int testsRun = 0;
  int testsFailed = 0;

  // reference model state
  logic [DW-1:0] mShadow [NR];
  logic [NR-1:0] mDirty;
  int            mLast;
  bit            mWait;
  bit            mPush;
  int            mFreeAt;
  int            cycle;
  logic [XW-1:0] mInflight;
  int            mCoalesced;
  int            mSent;

  logic [XW-1:0] pushLog[$];

  always #5 iclk = ~iclk;

  reg_xing_feeder #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW)
  ) dut (
    .iclk           (iclk),
    .ireset         (ireset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .xing_data      (xing_data),
    .xing_push      (xing_push),
    .xing_ready     (xing_ready),
    .pending        (pending),
    .idle           (idle),
    .stat_coalesced (stat_coalesced),
    .stat_sent      (stat_sent)
  );

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XW-1:0] logEntry(input int k);
    logic [XW-1:0] none;
    none = '1;
    if (k < pushLog.size()) return pushLog[k];
    return none;
  endfunction

  // Advance the reference model by one clock using this cycle's inputs.
  task automatic modelStep(input logic rst, input logic en, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic rdy);
    int picked;
    picked = -1;
    if (rst) begin
      for (int i = 0; i < NR; i++) mShadow[i] = '0;
      mDirty     = '0;
      mLast      = NR - 1;
      mWait      = 1'b0;
      mPush      = 1'b0;
      mFreeAt    = 0;
      mInflight  = '0;
      mCoalesced = 0;
      mSent      = 0;
    end else begin
      mPush = 1'b0;
      if (mWait) begin
        if (rdy) begin
          mPush   = 1'b1;
          mWait   = 1'b0;
          mFreeAt = cycle + 2;
          if (mSent < 65535) mSent++;
        end
      end else if (cycle >= mFreeAt && mDirty != '0) begin
        for (int off = 1; off <= NR; off++) begin
          int idx;
          idx = (mLast + off) % NR;
          if (mDirty[idx] && picked < 0) picked = idx;
        end
        mInflight      = {AW'(picked), mShadow[picked]};
        mDirty[picked] = 1'b0;
        mLast          = picked;
        mWait          = 1'b1;
      end
      if (en && int'(addr) < NR) begin
        if (mDirty[addr] && mCoalesced < 65535) mCoalesced++;
        mShadow[addr] = data;
        mDirty[addr]  = 1'b1;
      end
    end
    cycle++;
  endtask

  task automatic checkOutput();
    bit expIdle;
    expIdle = !mWait && !mPush && (mDirty == '0);
    expectEq("push", 64'(xing_push), 64'(mPush));
    expectEq("xing_data", 64'(xing_data), 64'(mInflight));
    expectEq("pending", 64'(pending), 64'(mDirty));
    expectEq("idle", 64'(idle), 64'(expIdle));
    expectEq("stat_coalesced", 64'(stat_coalesced), STATS ? 64'(mCoalesced) : 64'd0);
    expectEq("stat_sent", 64'(stat_sent), STATS ? 64'(mSent) : 64'd0);
    if (xing_push === 1'b1) pushLog.push_back(xing_data);
  endtask

  // Drive one cycle of inputs (called at a negedge), clock it, then check.
  task automatic applyStimulus(input logic rst, input logic en, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic rdy);
    ireset     = rst;
    wr_en      = en;
    wr_addr    = addr;
    wr_data    = data;
    xing_ready = rdy;
    modelStep(rst, en, addr, data, rdy);
    @(posedge iclk);
    @(negedge iclk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0, rdy);
  endtask

  initial begin
    cycle = 0;
    @(negedge iclk);

    // reset state
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    expectEq("rst_idle", 64'(idle), 64'd1);
    expectEq("rst_pending", 64'(pending), 64'd0);
    expectEq("rst_xing_data", 64'(xing_data), 64'd0);
    expectEq("rst_push", 64'(xing_push), 64'd0);

    // single write, ready high
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1);
    idleCycles(6, 1'b1);
    expectEq("t1_push_count", 64'(pushLog.size()), 64'd1);
    expectEq("t1_data", 64'(logEntry(0)), 64'({3'd3, 32'hDEADBEEF}));
    expectEq("t1_pending", 64'(pending), 64'd0);
    expectEq("t1_idle", 64'(idle), 64'd1);

    // coalescing while the feeder is stalled on another entry
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h55, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'd3, 1'b0);
    idleCycles(10, 1'b1);
    expectEq("t2_push_count", 64'(pushLog.size()), 64'd2);
    expectEq("t2_first", 64'(logEntry(0)), 64'({3'd5, 32'h55}));
    expectEq("t2_second", 64'(logEntry(1)), 64'({3'd2, 32'd3}));
    expectEq("t2_coalesced", 64'(stat_coalesced), STATS ? 64'd2 : 64'd0);

    // round-robin order: transfer on 7 puts the pointer at 7, burst 7,0,5
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h70, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h05, 1'b1);
    idleCycles(15, 1'b1);
    expectEq("t3_push_count", 64'(pushLog.size()), 64'd4);
    expectEq("t3_order0", 64'(logEntry(1)), 64'({3'd0, 32'h00}));
    expectEq("t3_order1", 64'(logEntry(2)), 64'({3'd5, 32'h05}));
    expectEq("t3_order2", 64'(logEntry(3)), 64'({3'd7, 32'h77}));
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd0, 32'hA0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd7, 32'hA7, 1'b1);
    idleCycles(10, 1'b1);
    expectEq("t3b_push_count", 64'(pushLog.size()), 64'd2);
    expectEq("t3b_first", 64'(logEntry(0)), 64'({3'd0, 32'hA0}));
    expectEq("t3b_second", 64'(logEntry(1)), 64'({3'd7, 32'hA7}));

    // write collides with the pick of the same index
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd4, 32'hA, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd4, 32'hB, 1'b1);
    idleCycles(10, 1'b1);
    expectEq("t4_push_count", 64'(pushLog.size()), 64'd2);
    expectEq("t4_first", 64'(logEntry(0)), 64'({3'd4, 32'hA}));
    expectEq("t4_second", 64'(logEntry(1)), 64'({3'd4, 32'hB}));
    expectEq("t4_coalesced", 64'(stat_coalesced), STATS ? 64'd2 : 64'd0);

    // reset while in SEND with 1 in flight and 6 pending; write during reset
    pushLog.delete();
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd6, 32'h66, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'h22, 1'b1);
    idleCycles(8, 1'b1);
    expectEq("t5_push_count", 64'(pushLog.size()), 64'd0);
    expectEq("t5_pending", 64'(pending), 64'd0);
    expectEq("t5_idle", 64'(idle), 64'd1);
    expectEq("t5_xing_data", 64'(xing_data), 64'd0);
    expectEq("t5_sent", 64'(stat_sent), 64'd0);

    // counter saturation
    pushLog.delete();
    for (int i = 0; i < 70000; i++) applyStimulus(1'b0, 1'b1, 3'd3, DW'(i), 1'b0);
    expectEq("t6_coalesced_sat", 64'(stat_coalesced), STATS ? 64'hFFFF : 64'd0);
    idleCycles(10, 1'b1);
    expectEq("t6_last_push", 64'(logEntry(1)), 64'({3'd3, 32'd69999}));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, NR - 1)),
                    $urandom(),
                    ($urandom_range(0, 3) != 0));
    end
    idleCycles(40, 1'b1);
    expectEq("rand_drain_idle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_xing_feeder.md
REG_XING_FEEDER -- requirements
Module: reg_xing_feeder

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, giving the number of shadow registers (legal range 2..256).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each register.
REQ-003 The block SHALL derive ADDR_WIDTH = $clog2(NUM_REGS) internally; it SHALL NOT be a user parameter.
REQ-004 The block SHALL have the port `iclk  in  1`: clock, all ports synchronous to it.
REQ-005 The block SHALL have the port `ireset  in  1`: reset, synchronous, active-high.
REQ-006 The block SHALL have the port `wr_en  in  1`: register write strobe.
REQ-007 The block SHALL have the port `wr_addr  in  ADDR_WIDTH`: write index; values >= NUM_REGS are ignored.
REQ-008 The block SHALL have the port `wr_data  in  DATA_WIDTH`: write value.
REQ-009 The block SHALL have the port `xing_data  out  ADDR_WIDTH+DATA_WIDTH`: {index, value}, for the crossing stage's idata.
REQ-010 The block SHALL have the port `xing_push  out  1`: one-cycle push to the crossing stage.
REQ-011 The block SHALL have the port `xing_ready  in  1`: crossing-stage holdoff (its iready).
REQ-012 The block SHALL have the port `pending  out  NUM_REGS`: dirty bitmap.
REQ-013 The block SHALL have the port `idle  out  1`: high when nothing is dirty and the FSM is in IDLE.
REQ-014 The block SHALL have the ports `stat_coalesced`, `stat_sent`  out  16 each: statistics counters (see Configuration).

Function
REQ-015 A write with wr_en=1 and a legal wr_addr SHALL update shadow[wr_addr] and set dirty[wr_addr] on the next edge.
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND and HOLD.
REQ-017 In IDLE, when dirty is nonzero, the block SHALL pick index i by round-robin, searching from last+1 upward and wrapping at NUM_REGS.
REQ-018 On that pick the block SHALL register xing_data={i,shadow[i]}, clear dirty[i], set last=i and move to SEND.
REQ-019 If a write hits index i in the same cycle i is picked, the block SHALL load the old shadow value, and dirty[i] SHALL remain set so the new value is sent later.
REQ-020 In SEND, the block SHALL stay while xing_ready=0 and move to HOLD on the first cycle with xing_ready=1.
REQ-021 xing_push SHALL be registered and high for exactly the one cycle the FSM is in HOLD.
REQ-022 HOLD SHALL move to IDLE unconditionally.
REQ-023 The downstream stage SHALL deassert xing_ready within one cycle after the push; the HOLD state absorbs that latency.
REQ-024 xing_data SHALL remain stable from entry to SEND until the next pick.
REQ-025 Writes SHALL be accepted every cycle regardless of FSM state, with no backpressure.
REQ-026 Repeated writes to an already-dirty index SHALL coalesce, so only the latest value is sent.
REQ-027 Latency from a write to xing_push SHALL be 3 cycles minimum (write edge, pick, SEND with ready, HOLD).
REQ-028 pending SHALL equal dirty.
REQ-029 idle SHALL equal (state==IDLE && dirty==0).

Reset
REQ-030 When ireset=1, shadow, dirty, xing_data, xing_push and both counters SHALL be set to 0, state SHALL be IDLE and last SHALL be NUM_REGS-1.
REQ-031 Reset asserted mid-operation (SEND or HOLD) SHALL discard the in-flight entry and all pending entries, and no push SHALL follow.
REQ-032 A write presented in the same cycle as reset SHALL be ignored.

Configuration
REQ-033 The macro REG_XING_FEEDER_STATS_EN SHALL control the statistics counters.
REQ-034 With REG_XING_FEEDER_STATS_EN defined, stat_coalesced SHALL increment, saturating at 0xFFFF, on each write to an index whose dirty bit is already set and is not being cleared that cycle.
REQ-035 With REG_XING_FEEDER_STATS_EN defined, stat_sent SHALL increment, saturating at 0xFFFF, on each xing_push.
REQ-036 With REG_XING_FEEDER_STATS_EN undefined, both ports SHALL remain present, SHALL be tied to 0, and SHALL infer no counter logic.

Structure
REQ-037 Package reg_xing_pkg SHALL hold the FSM state enum (IDLE/SEND/HOLD) and the STAT_WIDTH=16 constant.
REQ-038 Round-robin selection SHALL be one sub-module, rr_pick: inputs request vector and last index; outputs grant index and any-valid.
REQ-039 The block SHALL contain no clock-domain crossing logic; xing_data, xing_push and xing_ready connect directly to the downstream crossing stage.

Verification
REQ-040 The bench SHALL cover: reset, write addr 3 = 0xDEADBEEF with xing_ready=1 -> one xing_push, xing_data={3,0xDEADBEEF}, pending=0, idle=1.
REQ-041 The bench SHALL cover: xing_ready=0, write addr 2 = 1, 2, 3 on consecutive cycles, then ready=1 -> single push {2,3}; stat_coalesced=2 (STATS_EN).
REQ-042 The bench SHALL cover: writes to 7, 0, 5 in one burst with ready=1 -> push order 0, 5, 7; then write 0 and 7 -> order 0, 7.
REQ-043 The bench SHALL cover: write addr 4 = 0xA, then 0xB in the cycle 4 is picked -> two pushes, {4,0xA} then {4,0xB}.
REQ-044 The bench SHALL cover: ireset pulsed while in SEND with addrs 1 and 6 dirty -> no push, pending=0, idle=1, xing_data=0.
REQ-045 The bench SHALL cover: 70000 writes to a dirty index with ready=0 -> stat_coalesced holds 0xFFFF; with STATS_EN undefined it reads 0.
